usb_rw_sequencer: RTL and testbench

- Host-side read/write sequencer that turns one memory-page read or write request into a two-phase USB transaction series.
- Phase 1 is an OUT transaction carrying the 16-bit page address to ADDR_ENDP.
- Phase 2 is an OUT transaction carrying the 64-bit data to DATA_ENDP (write), or an IN transaction from DATA_ENDP (read).
- Sits between the user/host interface and the OUT and IN transaction engines. Owns their start handshakes, retries and a watchdog.

---
 rtl/usb_pkg.sv | 32 +++
 rtl/usb_phase_timer.sv | 52 +++++
 rtl/usb_rw_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_usb_rw_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared types and defaults for the USB page read/write sequencer.
package usb_pkg;

  localparam logic [3:0]  USB_ADDR_ENDP = 4'd4;
  localparam logic [3:0]  USB_DATA_ENDP = 4'd8;
  localparam int unsigned USB_DATA_W    = 64;
  localparam int unsigned USB_WDOG_W    = 16;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_OUT,
    DATA_OUT,
    DATA_IN,
    FINISH
  } rw_state_t;

  typedef struct packed {
    logic done;
    logic success;
    logic failure;
  } xact_result_t;

  // An engine reporting both success and failure is treated as a failure.
  function automatic logic xact_ok(input xact_result_t r);
    return r.done & r.success & ~r.failure;
  endfunction

  function automatic logic xact_fail(input xact_result_t r);
    return r.done & ~xact_ok(r);
  endfunction

endpackage

// File: rtl/usb_phase_timer.sv
// Per-phase watchdog and retry counters for the read/write sequencer.
module usb_phase_timer
  import usb_pkg::*;
#(
  parameter logic [USB_WDOG_W-1:0] WDOG_CYCLES = 16'd50000,
  parameter int unsigned           MAX_RETRY   = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic wdog_clr,
  input  logic wdog_inc,
  input  logic retry_clr,
  input  logic retry_inc,
  output logic wdog_expired_c,
  output logic retry_left_c
);

  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  logic [USB_WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic [RETRY_W-1:0]    retry_cnt_q, retry_cnt_d;

  // Clear has priority so a new attempt always starts counting from zero.
  always_comb begin
    wdog_cnt_d  = wdog_cnt_q;
    retry_cnt_d = retry_cnt_q;
    if (wdog_clr) begin
      wdog_cnt_d = '0;
    end else if (wdog_inc) begin
      wdog_cnt_d = wdog_cnt_q + USB_WDOG_W'(1);
    end
    if (retry_clr) begin
      retry_cnt_d = '0;
    end else if (retry_inc) begin
      retry_cnt_d = retry_cnt_q + RETRY_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wdog_cnt_q  <= '0;
      retry_cnt_q <= '0;
    end else begin
      wdog_cnt_q  <= wdog_cnt_d;
      retry_cnt_q <= retry_cnt_d;
    end
  end

  assign wdog_expired_c = (wdog_cnt_q == (WDOG_CYCLES - USB_WDOG_W'(1)));
  assign retry_left_c   = (retry_cnt_q < RETRY_W'(MAX_RETRY));

endmodule

// File: rtl/usb_rw_sequencer.sv
// Turns one page read/write request into an address OUT followed by a data OUT or IN,
// with per-phase retries and a watchdog.
module usb_rw_sequencer
  import usb_pkg::*;
#(
  parameter logic [3:0]            ADDR_ENDP   = USB_ADDR_ENDP,
  parameter logic [3:0]            DATA_ENDP   = USB_DATA_ENDP,
  parameter int unsigned           MAX_RETRY   = 2,
  parameter logic [USB_WDOG_W-1:0] WDOG_CYCLES = 16'd50000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        read_req,
  input  logic        write_req,
  input  logic [15:0] mempage,
  input  logic [63:0] wr_data,
  output logic [63:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        success,
  output logic        failure,
  output logic [3:0]  endp,
  output logic [63:0] payload,
  output logic        out_start,
  input  logic        out_done,
  input  logic        out_success,
  input  logic        out_failure,
  output logic        in_start,
  input  logic        in_done,
  input  logic        in_success,
  input  logic        in_failure,
  input  logic [63:0] in_data
);

  rw_state_t             state_q, state_d;
  logic                  is_read_q, is_read_d;
  logic [USB_DATA_W-1:0] wdata_q, wdata_d;
  logic [USB_DATA_W-1:0] rd_data_q, rd_data_d;
  logic [USB_DATA_W-1:0] payload_q, payload_d;
  logic [3:0]            endp_q, endp_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  success_q, success_d;
  logic                  failure_q, failure_d;
  logic                  out_start_q, out_start_d;
  logic                  in_start_q, in_start_d;

  logic                  wdog_clr, retry_clr, retry_inc;
  logic                  wdog_expired_c, retry_left_c;
  logic                  fin, fin_ok;
  xact_result_t          res;

  usb_phase_timer #(
    .WDOG_CYCLES (WDOG_CYCLES),
    .MAX_RETRY   (MAX_RETRY)
  ) u_timer (
    .clock          (clock),
    .reset_n        (reset_n),
    .wdog_clr       (wdog_clr),
    .wdog_inc       (busy_q),
    .retry_clr      (retry_clr),
    .retry_inc      (retry_inc),
    .wdog_expired_c (wdog_expired_c),
    .retry_left_c   (retry_left_c)
  );

  // Next-state and registered-output logic; only the active engine's result is looked at.
  always_comb begin
    state_d     = state_q;
    is_read_d   = is_read_q;
    wdata_d     = wdata_q;
    rd_data_d   = rd_data_q;
    payload_d   = payload_q;
    endp_d      = endp_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    success_d   = 1'b0;
    failure_d   = 1'b0;
    out_start_d = 1'b0;
    in_start_d  = 1'b0;
    wdog_clr    = 1'b0;
    retry_clr   = 1'b0;
    retry_inc   = 1'b0;
    fin         = 1'b0;
    fin_ok      = 1'b0;
    res         = (state_q == DATA_IN) ? '{in_done, in_success, in_failure}
                                       : '{out_done, out_success, out_failure};

    unique case (state_q)
      IDLE: begin
        if (read_req && write_req) begin
          done_d    = 1'b1;
          failure_d = 1'b1;
        end else if (read_req || write_req) begin
          state_d     = ADDR_OUT;
          is_read_d   = read_req;
          wdata_d     = wr_data;
          payload_d   = USB_DATA_W'(mempage);
          endp_d      = ADDR_ENDP;
          busy_d      = 1'b1;
          out_start_d = 1'b1;
          wdog_clr    = 1'b1;
          retry_clr   = 1'b1;
        end
      end

      ADDR_OUT, DATA_OUT, DATA_IN: begin
        if (xact_ok(res)) begin
          if (state_q == ADDR_OUT) begin
            endp_d    = DATA_ENDP;
            wdog_clr  = 1'b1;
            retry_clr = 1'b1;
            if (is_read_q) begin
              state_d    = DATA_IN;
              payload_d  = '0;
              in_start_d = 1'b1;
            end else begin
              state_d     = DATA_OUT;
              payload_d   = wdata_q;
              out_start_d = 1'b1;
            end
          end else begin
            if (state_q == DATA_IN) begin
              rd_data_d = in_data;
            end
            fin    = 1'b1;
            fin_ok = 1'b1;
          end
        end else if (xact_fail(res)) begin
          if (retry_left_c) begin
            retry_inc = 1'b1;
            wdog_clr  = 1'b1;
            if (state_q == DATA_IN) begin
              in_start_d = 1'b1;
            end else begin
              out_start_d = 1'b1;
            end
          end else begin
            fin = 1'b1;
          end
        end else if (wdog_expired_c) begin
          fin = 1'b1;
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (fin) begin
      state_d   = FINISH;
      busy_d    = 1'b0;
      endp_d    = '0;
      payload_d = '0;
      done_d    = 1'b1;
      success_d = fin_ok;
      failure_d = ~fin_ok;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      is_read_q   <= 1'b0;
      wdata_q     <= '0;
      rd_data_q   <= '0;
      payload_q   <= '0;
      endp_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      success_q   <= 1'b0;
      failure_q   <= 1'b0;
      out_start_q <= 1'b0;
      in_start_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      is_read_q   <= is_read_d;
      wdata_q     <= wdata_d;
      rd_data_q   <= rd_data_d;
      payload_q   <= payload_d;
      endp_q      <= endp_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      success_q   <= success_d;
      failure_q   <= failure_d;
      out_start_q <= out_start_d;
      in_start_q  <= in_start_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign success   = success_q;
  assign failure   = failure_q;
  assign endp      = endp_q;
  assign payload   = payload_q;
  assign out_start = out_start_q;
  assign in_start  = in_start_q;

endmodule

// File: tb/tb_usb_rw_sequencer.sv
// Self-checking bench for usb_rw_sequencer: directed table, hand sequences and random requests
// checked against an attempt-level timing model.
module tb_usb_rw_sequencer;

  localparam int WDOG      = 16;
  localparam int MAX_RETRY = 2;
  localparam int BUDGET    = 300;
  localparam logic [3:0] A_EP = 4'd4;
  localparam logic [3:0] D_EP = 4'd8;

  logic        clock, reset_n;
  logic        read_req, write_req;
  logic [15:0] mempage;
  logic [63:0] wr_data, rd_data, payload, in_data;
  logic        busy, done, success, failure, out_start, in_start;
  logic        out_done, out_success, out_failure, in_done, in_success, in_failure;
  logic [3:0]  endp;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_rd = '0;

  // op: 0 write, 1 read, 2 both requests; af/df: failures before success per phase
  typedef struct {
    int          op;
    logic [15:0] page;
    logic [63:0] wdata;
    logic [63:0] idata;
    int          af;
    int          df;
    bit          silent;
    int          dly;
    bit          stray;
    int          exp_t;
    bit          exp_ok;
    int          exp_nout;
    int          exp_nin;
  } vec_t;

  vec_t vecs[12];

  usb_rw_sequencer #(
    .ADDR_ENDP   (4'd4),
    .DATA_ENDP   (4'd8),
    .MAX_RETRY   (2),
    .WDOG_CYCLES (16'd16)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .read_req    (read_req),
    .write_req   (write_req),
    .mempage     (mempage),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .busy        (busy),
    .done        (done),
    .success     (success),
    .failure     (failure),
    .endp        (endp),
    .payload     (payload),
    .out_start   (out_start),
    .out_done    (out_done),
    .out_success (out_success),
    .out_failure (out_failure),
    .in_start    (in_start),
    .in_done     (in_done),
    .in_success  (in_success),
    .in_failure  (in_failure),
    .in_data     (in_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"},      64'(busy),      64'(0));
    check({tag, ".done"},      64'(done),      64'(0));
    check({tag, ".success"},   64'(success),   64'(0));
    check({tag, ".failure"},   64'(failure),   64'(0));
    check({tag, ".out_start"}, 64'(out_start), 64'(0));
    check({tag, ".in_start"},  64'(in_start),  64'(0));
    check({tag, ".endp"},      64'(endp),      64'(0));
    check({tag, ".payload"},   payload,        64'(0));
    check({tag, ".rd_data"},   rd_data,        64'(0));
  endtask

  // Timing model: each attempt occupies dly+1 cycles from its start; a silent or too-slow
  // engine ends the request WDOG cycles after that attempt's start.
  function automatic void model(inout vec_t v);
    int t;
    int fails;
    bit ph_ok;
    v.exp_nout = 0;
    v.exp_nin  = 0;
    v.exp_ok   = 1'b0;
    if (v.op == 2) begin
      v.exp_t = 1;
      return;
    end
    t = 1;
    for (int ph = 0; ph < 2; ph++) begin
      fails = (ph == 0) ? v.af : v.df;
      ph_ok = 1'b0;
      for (int k = 0; k <= MAX_RETRY && !ph_ok; k++) begin
        if (ph == 1 && v.op == 1) v.exp_nin++;
        else v.exp_nout++;
        if ((ph == 1 && v.silent) || v.dly >= WDOG) begin
          v.exp_t = t + WDOG;
          return;
        end
        if (k >= fails) ph_ok = 1'b1;
        else if (k == MAX_RETRY) begin
          v.exp_t = t + v.dly + 1;
          return;
        end
        t = t + v.dly + 1;
      end
    end
    v.exp_t  = t;
    v.exp_ok = 1'b1;
  endfunction

  // Drives one request and plays both engines; t counts cycles after the request cycle.
  task automatic run_txn(input vec_t v, input string tag);
    int t, nout, nin, resp_t, stray_t, att, t_done, busy_bad;
    bit data_ph, pend_in, pending, got_s, got_f, pass;
    logic [63:0] rd_at_done;
    t = 0; nout = 0; nin = 0; resp_t = -1; stray_t = -1; att = 0; t_done = -1; busy_bad = 0;
    data_ph = 0; pend_in = 0; pending = 0; got_s = 0; got_f = 0; pass = 0; rd_at_done = '0;
    @(negedge clock);
    read_req  = (v.op != 0);
    write_req = (v.op != 1);
    mempage   = v.page;
    wr_data   = v.wdata;
    while (t_done < 0 && t < BUDGET) begin
      @(negedge clock);
      t++;
      read_req  = 1'b0;
      write_req = 1'b0;
      {out_done, out_success, out_failure, in_done, in_success, in_failure} = '0;
      if (busy !== ((v.op != 2) && (t < v.exp_t))) busy_bad++;
      if (done === 1'b1) begin
        t_done     = t;
        got_s      = success;
        got_f      = failure;
        rd_at_done = rd_data;
        pending    = 1'b0;
        check({tag, ".fin_endp"},    64'(endp), 64'(0));
        check({tag, ".fin_payload"}, payload,   64'(0));
      end
      if (out_start === 1'b1) begin
        nout++;
        att++;
        check({tag, ".start_endp"}, 64'(endp), 64'(data_ph ? D_EP : A_EP));
        check({tag, ".start_payload"}, payload, data_ph ? v.wdata : 64'(v.page));
        if (!(data_ph && v.silent)) begin
          pending = 1'b1; pend_in = 1'b0; resp_t = t + v.dly;
        end
        if (data_ph && v.stray) stray_t = t + 1;
      end
      if (in_start === 1'b1) begin
        nin++;
        att++;
        check({tag, ".in_endp"}, 64'(endp), 64'(D_EP));
        if (!v.silent) begin
          pending = 1'b1; pend_in = 1'b1; resp_t = t + v.dly;
        end
      end
      if (t == stray_t) begin
        in_done = 1'b1; in_success = 1'b1; in_data = ~v.idata;
      end
      if (pending && t == resp_t) begin
        pending = 1'b0;
        pass = (att > (data_ph ? v.df : v.af));
        if (pend_in) begin
          in_done     = 1'b1;
          in_success  = pass | 1'($urandom_range(0, 1));
          in_failure  = !pass;
          in_data     = pass ? v.idata : {$urandom, $urandom};
        end else begin
          out_done    = 1'b1;
          out_success = pass | 1'($urandom_range(0, 1));
          out_failure = !pass;
        end
        if (pass && !data_ph) begin
          data_ph = 1'b1;
          att     = 0;
        end
      end
    end
    {out_done, out_success, out_failure, in_done, in_success, in_failure} = '0;
    check({tag, ".done_cycle"}, 64'(t_done), 64'(v.exp_t));
    check({tag, ".success"},    64'(got_s),  64'(v.exp_ok));
    check({tag, ".failure"},    64'(got_f),  64'(!v.exp_ok));
    check({tag, ".n_out"},      64'(nout),   64'(v.exp_nout));
    check({tag, ".n_in"},       64'(nin),    64'(v.exp_nin));
    check({tag, ".busy_trace"}, 64'(busy_bad), 64'(0));
    if (v.op == 1 && v.exp_ok) exp_rd = v.idata;
    check({tag, ".rd_data"}, rd_at_done, exp_rd);
    @(negedge clock);
    check({tag, ".after_done"}, 64'({done, busy}), 64'(0));
  endtask

  initial begin
    bit saw_done;
    reset_n = 1'b1;
    {read_req, write_req, out_done, out_success, out_failure} = '0;
    {in_done, in_success, in_failure} = '0;
    mempage = '0; wr_data = '0; in_data = '0;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check_all_zero("reset");
    reset_n = 1'b1;

    //           op page      wdata                  idata                  af df sil dly str  t  ok no ni
    vecs[0]  = '{0, 16'h1234, 64'hDEAD_BEEF_0000_0001, 64'h0,                0, 0, 0, 2,  0, 7,  1, 2, 0};
    vecs[1]  = '{1, 16'h0777, 64'h0,                  64'hCAFE_F00D_1111_2222, 0, 0, 0, 2,  0, 7,  1, 1, 1};
    vecs[2]  = '{0, 16'h00AA, 64'h1111_2222_3333_4444, 64'h0,                2, 0, 0, 1,  0, 9,  1, 4, 0};
    vecs[3]  = '{0, 16'h00AB, 64'h5555_6666_7777_8888, 64'h0,                3, 0, 0, 1,  0, 7,  0, 3, 0};
    vecs[4]  = '{1, 16'h0101, 64'h0,                  64'h9999_AAAA_BBBB_CCCC, 0, 0, 1, 2,  0, 20, 0, 1, 1};
    vecs[5]  = '{2, 16'h0202, 64'h0,                  64'h0,                0, 0, 0, 2,  0, 1,  0, 0, 0};
    vecs[6]  = '{1, 16'h0303, 64'h0,                  64'h0123_0456_0789_0ABC, 0, 1, 0, 3,  0, 13, 1, 1, 2};
    vecs[7]  = '{0, 16'h0404, 64'hFEED_FACE_0000_0007, 64'h0,                0, 0, 0, 15, 0, 33, 1, 2, 0};
    vecs[8]  = '{0, 16'h0505, 64'h0000_0000_0000_0008, 64'h0,                0, 0, 0, 16, 0, 17, 0, 1, 0};
    vecs[9]  = '{0, 16'h0606, 64'hABCD_0000_0000_0009, 64'h1357_9BDF_0246_8ACE, 0, 0, 0, 3,  1, 9,  1, 2, 0};
    vecs[10] = '{0, 16'h0707, 64'h0000_0000_0000_000A, 64'h0,                0, 3, 0, 2,  0, 13, 0, 4, 0};
    vecs[11] = '{1, 16'h0808, 64'h0,                  64'hDEAD_DEAD_DEAD_DEAD, 0, 3, 0, 1,  0, 9,  0, 1, 3};
    for (int i = 0; i < 12; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // A request held high through FINISH is accepted in the next IDLE cycle.
    @(negedge clock);
    write_req = 1'b1; mempage = 16'h00A5; wr_data = 64'h0123_4567_89AB_CDEF;
    @(negedge clock);
    check("hold.start1", 64'({out_start, endp}), 64'({1'b1, A_EP}));
    @(negedge clock);
    out_done = 1'b1; out_success = 1'b1;
    @(negedge clock);
    out_done = 1'b0; out_success = 1'b0;
    check("hold.start2", 64'({out_start, endp}), 64'({1'b1, D_EP}));
    @(negedge clock);
    out_done = 1'b1; out_success = 1'b1;
    @(negedge clock);
    out_done = 1'b0; out_success = 1'b0;
    check("hold.done", 64'({done, success, failure}), 64'(3'b110));
    @(negedge clock);
    check("hold.idle", 64'({busy, out_start}), 64'(0));
    @(negedge clock);
    write_req = 1'b0;
    check("hold.restart", 64'({out_start, busy, endp}), 64'({2'b11, A_EP}));
    check("hold.payload", payload, 64'h0000_0000_0000_00A5);

    // Asynchronous reset in the data OUT phase: outputs clear mid-cycle, no done follows.
    @(negedge clock);
    out_done = 1'b1; out_success = 1'b1;
    @(negedge clock);
    out_done = 1'b0; out_success = 1'b0;
    check("rst.data_phase", 64'({busy, endp}), 64'({1'b1, D_EP}));
    #2 reset_n = 1'b0;
    #1 check_all_zero("rst_async");
    exp_rd = '0;
    @(negedge clock);
    reset_n = 1'b1;
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clock);
      saw_done |= done;
    end
    check("rst.no_done", 64'({saw_done, busy}), 64'(0));

    // Random requests against the timing model.
    for (int i = 0; i < 40; i++) begin
      vec_t v;
      int r;
      r = int'($urandom_range(0, 7));
      v.op     = (r < 4) ? 0 : ((r < 7) ? 1 : 2);
      v.page   = 16'($urandom);
      v.wdata  = {$urandom, $urandom};
      v.idata  = {$urandom, $urandom};
      v.af     = int'($urandom_range(0, 3));
      v.df     = int'($urandom_range(0, 3));
      v.silent = (v.op == 1) && ($urandom_range(0, 3) == 0);
      v.dly    = int'($urandom_range(1, 17));
      v.stray  = (v.op == 0) && ($urandom_range(0, 1) == 1);
      model(v);
      run_txn(v, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
